// File: rtl/clk_gate_ce_if.sv
// clk_gate_ce bus: enable requests in, gated clock and statistics out.
// The master drives the requests; the gating cell is the slave.
interface clk_gate_ce_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 ce;
    logic                 test_en;
    logic                 stat_clr;
    logic                 gclk;
    logic                 gate_open;
    logic [CNT_WIDTH-1:0] active_cycles;
    logic [CNT_WIDTH-1:0] gated_cycles;

    modport master (
        output ce,
        output test_en,
        output stat_clr,
        input  gclk,
        input  gate_open,
        input  active_cycles,
        input  gated_cycles
    );

    modport slave (
        input  ce,
        input  test_en,
        input  stat_clr,
        output gclk,
        output gate_open,
        output active_cycles,
        output gated_cycles
    );
endinterface

// File: rtl/clk_gate_ce.sv
// Glitch-free CE clock gate with enable hysteresis, test bypass
// and saturating pulsed/suppressed cycle counters.
module clk_gate_ce #(
    parameter bit ENABLE_GATING = 1'b1,
    parameter int HOLD_CYCLES   = 0,
    parameter int CNT_WIDTH     = 32
) (
    input logic            clk,
    input logic            rst,
    clk_gate_ce_if.slave   bus
);
    localparam int HW =
        (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 en_eff;
    logic                 en_lat;
    logic [HW-1:0]        hold_q;
    logic [HW-1:0]        hold_d;
    logic                 gate_open_q;
    logic                 gate_open_d;
    logic [CNT_WIDTH-1:0] act_q;
    logic [CNT_WIDTH-1:0] act_d;
    logic [CNT_WIDTH-1:0] gat_q;
    logic [CNT_WIDTH-1:0] gat_d;

    // Reset forces the clock on so downstream resets see edges.
    always_comb begin
        en_eff = bus.ce | bus.test_en | rst | (hold_q != '0);
    end

    // Enable latch: open in clk low phase, frozen while clk is high.
    always_latch begin
        if (!clk) begin
            en_lat = en_eff;
        end
    end

    if (ENABLE_GATING) begin : g_gate
        assign bus.gclk = clk & en_lat;
    end else begin : g_bypass
        assign bus.gclk = clk;
    end

    // Next-state for hold counter, gate status and statistics.
    always_comb begin
        hold_d = hold_q;
        if (HOLD_CYCLES == 0) begin
            hold_d = '0;
        end else if (bus.ce) begin
            hold_d = HOLD_LD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        gate_open_d = en_lat;

        act_d = act_q;
        gat_d = gat_q;
        if (bus.stat_clr) begin
            act_d = '0;
            gat_d = '0;
        end else if (en_lat) begin
            if (act_q != CNT_MAX) begin
                act_d = act_q + 1'b1;
            end
        end else begin
            if (gat_q != CNT_MAX) begin
                gat_d = gat_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            gate_open_q <= 1'b0;
            act_q       <= '0;
            gat_q       <= '0;
        end else begin
            hold_q      <= hold_d;
            gate_open_q <= gate_open_d;
            act_q       <= act_d;
            gat_q       <= gat_d;
        end
    end

    assign bus.gate_open     = gate_open_q;
    assign bus.active_cycles = act_q;
    assign bus.gated_cycles  = gat_q;
endmodule

// File: tb/tb_clk_gate_ce.sv
// Bench for clk_gate_ce: three configurations driven in lockstep,
// checked every cycle against an edge-level model plus literals.
module tb_clk_gate_ce;
    logic clk;
    logic rst;
    logic ce;
    logic te;
    logic sc;

    clk_gate_ce_if #(.CNT_WIDTH(8)) ia ();
    clk_gate_ce_if #(.CNT_WIDTH(4)) ib ();
    clk_gate_ce_if #(.CNT_WIDTH(8)) ic ();

    assign ia.ce = ce;
    assign ia.test_en = te;
    assign ia.stat_clr = sc;
    assign ib.ce = ce;
    assign ib.test_en = te;
    assign ib.stat_clr = sc;
    assign ic.ce = ce;
    assign ic.test_en = te;
    assign ic.stat_clr = sc;

    clk_gate_ce #(
        .ENABLE_GATING(1'b1),
        .HOLD_CYCLES(0),
        .CNT_WIDTH(8)
    ) u_a (
        .clk(clk),
        .rst(rst),
        .bus(ia.slave)
    );

    clk_gate_ce #(
        .ENABLE_GATING(1'b1),
        .HOLD_CYCLES(3),
        .CNT_WIDTH(4)
    ) u_b (
        .clk(clk),
        .rst(rst),
        .bus(ib.slave)
    );

    clk_gate_ce #(
        .ENABLE_GATING(1'b0),
        .HOLD_CYCLES(0),
        .CNT_WIDTH(8)
    ) u_c (
        .clk(clk),
        .rst(rst),
        .bus(ic.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(string nm, longint a, longint e);
        n_cmp++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // Observed gclk rising edges per instance.
    int e0 = 0;
    int e1 = 0;
    int e2 = 0;
    always @(posedge ia.gclk) e0++;
    always @(posedge ib.gclk) e1++;
    always @(posedge ic.gclk) e2++;

    logic [31:0] o_act [3];
    logic [31:0] o_gat [3];
    logic        o_go  [3];
    logic        o_g   [3];
    always_comb begin
        o_act[0] = 32'(ia.active_cycles);
        o_act[1] = 32'(ib.active_cycles);
        o_act[2] = 32'(ic.active_cycles);
        o_gat[0] = 32'(ia.gated_cycles);
        o_gat[1] = 32'(ib.gated_cycles);
        o_gat[2] = 32'(ic.gated_cycles);
        o_go[0]  = ia.gate_open;
        o_go[1]  = ib.gate_open;
        o_go[2]  = ic.gate_open;
        o_g[0]   = ia.gclk;
        o_g[1]   = ib.gclk;
        o_g[2]   = ic.gclk;
    end

    function automatic int edges(int i);
        if (i == 0) return e0;
        if (i == 1) return e1;
        return e2;
    endfunction

    // Model: an edge passes if requested now, or if ce was seen
    // on one of the last HOLD edges with no reset since.
    int  hold_p [3] = '{0, 3, 0};
    bit  gate_p [3] = '{1'b1, 1'b1, 1'b0};
    int  max_p  [3] = '{255, 15, 255};
    int  k = 0;
    int  last_ce = 0;
    bit  have_ce = 1'b0;
    bit  xp  [3];
    int  xa  [3] = '{0, 0, 0};
    int  xg  [3] = '{0, 0, 0};
    bit  xo  [3];
    int  xe  [3] = '{0, 0, 0};
    int  go_cnt [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            xp[i] = ce | te | rst |
                    (have_ce && (k - last_ce) <= hold_p[i]);
            if (rst || sc) begin
                xa[i] = 0;
                xg[i] = 0;
            end else if (xp[i]) begin
                if (xa[i] < max_p[i]) xa[i]++;
            end else begin
                if (xg[i] < max_p[i]) xg[i]++;
            end
            xo[i] = rst ? 1'b0 : xp[i];
            xe[i] += (gate_p[i] ? int'(xp[i]) : 1);
        end
        if (rst) begin
            have_ce = 1'b0;
        end else if (ce) begin
            have_ce = 1'b1;
            last_ce = k;
        end
        k++;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gate_open[%0d]", i), o_go[i], xo[i]);
            chk($sformatf("active[%0d]", i), o_act[i], xa[i]);
            chk($sformatf("gated[%0d]", i), o_gat[i], xg[i]);
            chk($sformatf("gclk_hi[%0d]", i), o_g[i],
                gate_p[i] ? xp[i] : 1'b1);
            chk($sformatf("edges[%0d]", i), edges(i), xe[i]);
            go_cnt[i] += int'(o_go[i]);
        end
        #3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gclk_mid[%0d]", i), o_g[i],
                gate_p[i] ? xp[i] : 1'b1);
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gclk_lo[%0d]", i), o_g[i], 0);
        end
    end

    task automatic nxt(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int b0, b1, b2, bg;

    initial begin
        rst = 1'b1;
        ce = 1'b0;
        te = 1'b0;
        sc = 1'b0;
        nxt(3);
        rst = 1'b0;
        chk("rst_act", o_act[0], 0);
        chk("rst_gat", o_gat[0], 0);
        chk("rst_edges", e0, 3);
        nxt(5);
        chk("idle_gat", o_gat[0], 5);
        chk("idle_edges", e0, 3);

        // CE window, ce dropped mid-high on the last edge
        sc = 1'b1;
        nxt();
        sc = 1'b0;
        b0 = e0; b1 = e1; b2 = e2;
        ce = 1'b1;
        nxt(3);
        @(posedge clk);
        #2 ce = 1'b0;
        @(negedge clk);
        #1;
        nxt(3);
        chk("win_act_a", o_act[0], 4);
        chk("win_gat_a", o_gat[0], 3);
        chk("win_edges_a", e0 - b0, 4);
        chk("win_act_b", o_act[1], 7);
        chk("win_edges_b", e1 - b1, 7);
        chk("win_edges_c", e2 - b2, 7);
        chk("win_act_c", o_act[2], 4);

        // Hysteresis: single-cycle ce pulse
        sc = 1'b1;
        nxt();
        sc = 1'b0;
        b1 = e1;
        bg = go_cnt[1];
        ce = 1'b1;
        nxt();
        ce = 1'b0;
        nxt(6);
        chk("hys_edges_b", e1 - b1, 4);
        chk("hys_go_b", go_cnt[1] - bg, 4);
        chk("hys_act_b", o_act[1], 4);
        chk("hys_act_a", o_act[0], 1);
        chk("hys_gat_a", o_gat[0], 6);

        // Test bypass
        sc = 1'b1;
        nxt();
        sc = 1'b0;
        b0 = e0;
        te = 1'b1;
        nxt(10);
        te = 1'b0;
        chk("tst_edges_a", e0 - b0, 10);
        chk("tst_act_a", o_act[0], 10);
        chk("tst_gat_a", o_gat[0], 0);

        // Saturation and clear
        sc = 1'b1;
        nxt();
        sc = 1'b0;
        b2 = e2;
        nxt(20);
        chk("sat_gat_b", o_gat[1], 15);
        chk("sat_gat_a", o_gat[0], 20);
        chk("byp_gat_c", o_gat[2], 20);
        chk("byp_edges_c", e2 - b2, 20);
        sc = 1'b1;
        nxt();
        chk("clr_gat_b", o_gat[1], 0);
        chk("clr_gat_a", o_gat[0], 0);
        ce = 1'b1;
        nxt();
        chk("clr_en_act_a", o_act[0], 0);
        sc = 1'b0;
        ce = 1'b0;
        nxt();
        chk("post_act_a", o_act[0], 0);
        chk("post_gat_a", o_gat[0], 1);
        chk("post_act_b", o_act[1], 1);
        nxt(3);

        // test_en pulse inside a high phase must not glitch
        @(posedge clk);
        #2 te = 1'b1;
        #1 te = 1'b0;
        @(negedge clk);
        #1;
        nxt(2);

        // Reset in mid-operation
        ce = 1'b1;
        nxt(2);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        ce = 1'b0;
        nxt(5);
        chk("mid_gat_b", o_gat[1], 5);
        chk("mid_act_b", o_act[1], 0);
        nxt(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
